// File: rtl/review2015_timer_datapath_if.sv
// Signal bundle between the timer-control FSM (master) and its datapath (slave).
interface review2015_timer_datapath_if #(
    parameter int unsigned DELAY_W = 4
);
    logic               data;
    logic               shift_ena;
    logic               counting;
    logic [DELAY_W-1:0] count;
    logic               done_counting;
    logic               unit_tick;

    modport master (
        output data, shift_ena, counting,
        input  count, done_counting, unit_tick
    );

    modport slave (
        input  data, shift_ena, counting,
        output count, done_counting, unit_tick
    );
endinterface

// File: rtl/review2015_timer_datapath.sv
// Timer datapath: serially captures a delay value, then counts (delay+1) units
// of UNIT_CYCLES clocks and reports the remaining whole units on count.
module review2015_timer_datapath #(
    parameter int unsigned UNIT_CYCLES = 1000,
    parameter int unsigned DELAY_W     = 4
) (
    input logic                         clk,
    input logic                         reset,
    review2015_timer_datapath_if.slave  bus
);
    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [DELAY_W-1:0] r_dly;
    logic [CW-1:0]      r_cnt;
    logic               w_unit_end;
    logic               w_unit_tick;
    logic               w_done;

    always_comb begin
        w_unit_end  = (r_cnt == LAST);
        w_unit_tick = bus.counting & ~bus.shift_ena & w_unit_end;
        w_done      = w_unit_tick & (r_dly == '0);
    end

    // Shift has priority over counting so an illegal overlap stays deterministic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dly <= '0;
            r_cnt <= '0;
        end else if (bus.shift_ena) begin
            r_dly <= {r_dly[DELAY_W-2:0], bus.data};
            r_cnt <= '0;
        end else if (bus.counting) begin
            if (w_unit_end) begin
                r_cnt <= '0;
                if (r_dly != '0) begin
                    r_dly <= r_dly - 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign bus.count         = r_dly;
    assign bus.unit_tick     = w_unit_tick;
    assign bus.done_counting = w_done;
endmodule
